fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Response classification drives the drop/accept decision each cycle.
package fetch_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned INST_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_DROP,
    RESP_ACCEPT,
    RESP_SPURIOUS
  } resp_kind_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response, redirect, and
// decode-side instruction handshake.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic              i_imem_ready;
  logic              o_imem_ren;
  logic [XLEN-1:0]   o_imem_raddr;
  logic              i_imem_valid;
  logic [INST_W-1:0] i_imem_rdata;
  logic              i_redirect;
  logic [XLEN-1:0]   i_redirect_pc;
  logic              o_inst_valid;
  logic [INST_W-1:0] o_inst;
  logic [XLEN-1:0]   o_inst_pc;
  logic              i_inst_ready;

  modport master (
    input  i_imem_ready, i_imem_valid, i_imem_rdata,
    input  i_redirect, i_redirect_pc, i_inst_ready,
    output o_imem_ren, o_imem_raddr,
    output o_inst_valid, o_inst, o_inst_pc
  );

  modport slave (
    output i_imem_ready, i_imem_valid, i_imem_rdata,
    output i_redirect, i_redirect_pc, i_inst_ready,
    input  o_imem_ren, o_imem_raddr,
    input  o_inst_valid, o_inst, o_inst_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Count-tracked circular FIFO with synchronous flush; head is read directly
// from storage so there is no write-to-read bypass.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty, full, do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks in-flight PCs,
// buffers returned instructions, and discards stale responses after redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0,
  parameter int unsigned     DEPTH      = DEFAULT_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fetch_unit_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  logic [XLEN-1:0]        pc_q, pc_d;
  logic [CW-1:0]          drop_q, drop_d;
  logic [CW-1:0]          pcq_count, buf_count;
  logic [XLEN-1:0]        pcq_head;
  logic [INST_W+XLEN-1:0] buf_head;
  logic [CW+1:0]          occupancy;
  resp_kind_e             resp_kind;
  logic                   ren, issue, consume;
  logic                   pcq_pop, buf_push;

  always_comb begin
    resp_kind = RESP_NONE;
    // Dropped requests are older than anything in the PC queue, so they drain first.
    if (bus.i_imem_valid) begin
      if (drop_q != '0) begin
        resp_kind = RESP_DROP;
      end else if (pcq_count != '0) begin
        resp_kind = RESP_ACCEPT;
      end else begin
        resp_kind = RESP_SPURIOUS;
      end
    end

    occupancy = (CW+2)'(pcq_count) + (CW+2)'(drop_q) + (CW+2)'(buf_count);
    ren       = i_rst_n && !bus.i_redirect && (occupancy < DEPTH_W);
    issue     = ren && bus.i_imem_ready;
    consume   = (buf_count != '0) && bus.i_inst_ready;
    pcq_pop   = (resp_kind == RESP_ACCEPT);
    buf_push  = (resp_kind == RESP_ACCEPT) && !bus.i_redirect;

    pc_d   = pc_q;
    drop_d = drop_q;
    if (bus.i_redirect) begin
      pc_d   = word_align(bus.i_redirect_pc);
      // A response landing in the redirect cycle retires one outstanding request.
      drop_d = drop_q + pcq_count
             - CW'((resp_kind == RESP_DROP) || (resp_kind == RESP_ACCEPT));
    end else begin
      if (issue) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (resp_kind == RESP_DROP) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q   <= word_align(RESET_ADDR);
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (bus.i_redirect),
    .push  (issue),
    .wdata (pc_q),
    .pop   (pcq_pop),
    .rdata (pcq_head),
    .count (pcq_count)
  );

  fetch_fifo #(
    .WIDTH (INST_W + XLEN),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (bus.i_redirect),
    .push  (buf_push),
    .wdata ({bus.i_imem_rdata, pcq_head}),
    .pop   (consume),
    .rdata (buf_head),
    .count (buf_count)
  );

  assign bus.o_imem_ren   = ren;
  assign bus.o_imem_raddr = pc_q;
  assign bus.o_inst_valid = (buf_count != '0);
  assign bus.o_inst       = buf_head[INST_W+XLEN-1:XLEN];
  assign bus.o_inst_pc    = buf_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: memory model with ordered latency plus a
// queue-based reference of in-flight/buffered instructions checked every cycle.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RST_ADDR = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_ADDR (RST_ADDR),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // memory model
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          ready_mode;   // 0: every other cycle, 1: random, 2: never
  int          irdy_mode;    // 0: always, 1: never, 2: random
  int          lat_min, lat_max;
  int          redir_pct, spur_pct;
  bit          redir_force;
  logic [31:0] redir_force_pc;

  // reference model
  typedef struct {
    logic [31:0] addr;
    bit          live;
  } flight_t;
  flight_t     m_fl[$];
  logic [31:0] m_buf[$];
  logic [31:0] m_pc;

  // bookkeeping for directed checks
  int          cyc;
  int          n_issue;
  int          issue_cyc[3];
  logic [31:0] last_issue_addr;
  int          first_valid_cyc;
  bit          watch_pc;
  logic [31:0] watched_pc;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_imem_valid = 1'b0;
    bus.i_redirect   = 1'b0;
    #1;
    check_eq("rst_ren",        64'(bus.o_imem_ren),   64'(0));
    check_eq("rst_inst_valid", 64'(bus.o_inst_valid), 64'(0));
    check_eq("rst_raddr",      64'(bus.o_imem_raddr), 64'(RST_ADDR));
    check_eq("rst_inst",       64'(bus.o_inst),       64'(0));
    check_eq("rst_inst_pc",    64'(bus.o_inst_pc),    64'(0));
    mem_addr.delete();
    mem_due.delete();
    m_fl.delete();
    m_buf.delete();
    m_pc = RST_ADDR;
    n_issue = 0;
    first_valid_cyc = -1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic step();
    logic        redir, exp_ren, dut_issue, m_issue, consume, valid, resp_real;
    logic [31:0] rpc, issue_addr;
    int          due;
    redir = redir_force || (redir_pct != 0 && $urandom_range(0, 99) < redir_pct);
    rpc   = redir_force ? redir_force_pc : $urandom;
    redir_force = 1'b0;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = rpc;
    case (ready_mode)
      0:       bus.i_imem_ready = (cyc % 2 == 0);
      1:       bus.i_imem_ready = ($urandom_range(0, 3) != 0);
      default: bus.i_imem_ready = 1'b0;
    endcase
    case (irdy_mode)
      0:       bus.i_inst_ready = 1'b1;
      1:       bus.i_inst_ready = 1'b0;
      default: bus.i_inst_ready = ($urandom_range(0, 9) < 7);
    endcase
    resp_real = 1'b0;
    if (mem_due.size() != 0 && mem_due[0] <= cyc) begin
      resp_real = 1'b1;
      bus.i_imem_valid = 1'b1;
      bus.i_imem_rdata = mem_word(mem_addr[0]);
    end else if (mem_due.size() == 0 && spur_pct != 0 && $urandom_range(0, 99) < spur_pct) begin
      bus.i_imem_valid = 1'b1;
      bus.i_imem_rdata = $urandom;
    end else begin
      bus.i_imem_valid = 1'b0;
      bus.i_imem_rdata = $urandom;
    end
    #1;
    exp_ren = !redir && (m_fl.size() + m_buf.size() < DEPTH);
    check_eq("ren", 64'(bus.o_imem_ren), 64'(exp_ren));
    if (exp_ren) check_eq("raddr", 64'(bus.o_imem_raddr), 64'(m_pc));
    check_eq("inst_valid", 64'(bus.o_inst_valid), 64'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      check_eq("inst_pc", 64'(bus.o_inst_pc), 64'(m_buf[0]));
      check_eq("inst",    64'(bus.o_inst),    64'(mem_word(m_buf[0])));
    end
    if (bus.o_inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.o_inst_valid && watch_pc) begin
      watched_pc = bus.o_inst_pc;
      watch_pc   = 1'b0;
    end
    dut_issue  = bus.o_imem_ren && bus.i_imem_ready;
    issue_addr = bus.o_imem_raddr;
    m_issue    = exp_ren && bus.i_imem_ready;
    consume    = (m_buf.size() != 0) && bus.i_inst_ready;
    valid      = bus.i_imem_valid;
    @(posedge clk);
    if (resp_real) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (dut_issue) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (mem_due.size() != 0 && mem_due[$] + 1 > due) due = mem_due[$] + 1;
      mem_addr.push_back(issue_addr);
      mem_due.push_back(due);
      if (n_issue < 3) issue_cyc[n_issue] = cyc;
      n_issue++;
      last_issue_addr = issue_addr;
    end
    if (redir) begin
      if (valid && m_fl.size() != 0) void'(m_fl.pop_front());
      foreach (m_fl[i]) m_fl[i].live = 1'b0;
      m_buf.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (consume) void'(m_buf.pop_front());
      if (valid && m_fl.size() != 0) begin
        flight_t f;
        f = m_fl.pop_front();
        if (f.live) m_buf.push_back(f.addr);
      end
      if (m_issue) begin
        m_fl.push_back('{addr: m_pc, live: 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bus.i_imem_ready  = 1'b0;
    bus.i_imem_valid  = 1'b0;
    bus.i_imem_rdata  = '0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_inst_ready  = 1'b1;
    redir_force = 1'b0;
    watch_pc    = 1'b0;
    watched_pc  = '0;
    ready_mode = 0; irdy_mode = 0; lat_min = 4; lat_max = 4;
    redir_pct = 0; spur_pct = 0;
    last_issue_addr = '0;

    // startup timing with fixed latency 4 and request interval 2
    do_reset();
    for (int i = 0; i < 30; i++) step();
    check_eq("first_issue_cyc0", 64'(issue_cyc[0]), 64'(0));
    check_eq("first_issue_cyc1", 64'(issue_cyc[1]), 64'(2));
    check_eq("first_issue_cyc2", 64'(issue_cyc[2]), 64'(4));
    check_eq("first_valid_cyc",  64'(first_valid_cyc), 64'(5));

    // decode stalled: buffer fills, then one consume frees one slot
    do_reset();
    irdy_mode = 1;
    for (int i = 0; i < 24; i++) step();
    check_eq("stall_issue_count", 64'(n_issue), 64'(4));
    check_eq("stall_last_addr",   64'(last_issue_addr), 64'(32'hC));
    irdy_mode = 0;
    step();
    irdy_mode = 1;
    for (int i = 0; i < 12; i++) step();
    check_eq("resume_issue_count", 64'(n_issue), 64'(5));
    check_eq("resume_last_addr",   64'(last_issue_addr), 64'(32'h10));

    // redirect with two requests in flight
    do_reset();
    irdy_mode = 0;
    for (int i = 0; i < 3; i++) step();
    redir_force = 1'b1;
    redir_force_pc = 32'h42;
    watch_pc = 1'b1;
    for (int i = 0; i < 25; i++) step();
    check_eq("redirect_first_pc", 64'(watched_pc), 64'(32'h40));

    // spurious responses with nothing outstanding
    do_reset();
    ready_mode = 2; spur_pct = 50;
    for (int i = 0; i < 20; i++) step();

    // randomized traffic with redirects, stalls, spurious valids and a mid-run reset
    ready_mode = 1; irdy_mode = 2; lat_min = 1; lat_max = 6;
    redir_pct = 4; spur_pct = 5;
    do_reset();
    for (int i = 0; i < 1500; i++) step();
    do_reset();
    for (int i = 0; i < 1500; i++) step();
    redir_pct = 25;
    for (int i = 0; i < 500; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
